// File: rtl/counter_regs_pkg.sv
// Shared register map, bit positions and FSM state encoding for the
// Wishbone counter register block.
package counter_regs_pkg;

  localparam int unsigned OFF_W = 3;

  localparam logic [OFF_W-1:0] OFF_CTRL   = 3'd0;
  localparam logic [OFF_W-1:0] OFF_LOAD   = 3'd1;
  localparam logic [OFF_W-1:0] OFF_COUNT  = 3'd2;
  localparam logic [OFF_W-1:0] OFF_CMP    = 3'd3;
  localparam logic [OFF_W-1:0] OFF_STATUS = 3'd4;

  localparam int unsigned CTRL_W           = 2;
  localparam int unsigned CTRL_RUN_BIT     = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT  = 1;
  localparam int unsigned STATUS_MATCH_BIT = 0;
  localparam int unsigned STATUS_PEND_BIT  = 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACK       = 2'd1,
    ST_WAIT_LOAD = 2'd2
  } state_t;

  // Expand the four Wishbone byte enables into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/wb_counter_regs.sv
// Wishbone classic register slave controlling a downstream counter: run
// control, load handshake, live count readback. Compare/IRQ via COUNTER_CMP_IRQ_EN.
module wb_counter_regs
  import counter_regs_pkg::*;
#(
  parameter int unsigned BITS     = 16,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic [BITS-1:0] count_i,
  output logic            load_valid_o,
  output logic [BITS-1:0] load_data_o,
  input  logic            load_ready_i,
  output logic            run_o,
  output logic            irq_o
);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_commit;

  logic [CTRL_W-1:0] r_ctrl;
  logic [BITS-1:0]   r_load_data;
  logic              r_load_valid;
  logic              r_ack;
  logic [31:0]       r_dat;

  logic             w_hit;
  logic             w_load_wr;
  logic [OFF_W-1:0] w_off;
  logic [31:0]      w_mask;
  logic [31:0]      w_load_m32;
  logic [31:0]      w_rdata;
  logic [31:0]      w_status;
  logic [BITS-1:0]  w_cmp;
  logic             w_match;
  logic             w_wr_ctrl;
  logic             w_wr_load;
  logic             w_unused;

  assign w_off     = wbs_adr_i[4:2];
  assign w_hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == BASE_ADR[31:5]);
  assign w_load_wr = wbs_we_i & (w_off == OFF_LOAD);
  assign w_mask    = lane_mask(wbs_sel_i);

  assign w_load_m32 = (32'(r_load_data) & ~w_mask) | (wbs_dat_i & w_mask);
  assign w_wr_ctrl  = w_commit & wbs_we_i & (w_off == OFF_CTRL) & wbs_sel_i[0];
  assign w_wr_load  = w_commit & w_load_wr;

  // Upper merge bits beyond BITS and the byte-offset address bits are don't-care.
  assign w_unused = ^{wbs_adr_i[1:0], w_load_m32, wbs_dat_i, wbs_sel_i};

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state; a LOAD write that finds a load still pending parks in WAIT_LOAD
  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_hit) begin
          if (w_load_wr && r_load_valid) begin
            w_state_nxt = ST_WAIT_LOAD;
          end else begin
            w_commit    = 1'b1;
            w_state_nxt = ST_ACK;
          end
        end
      end
      ST_ACK: w_state_nxt = ST_IDLE;
      ST_WAIT_LOAD: begin
        if (!w_hit) begin
          w_state_nxt = ST_IDLE;
        end else if (!r_load_valid) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_ACK;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Read mux, sampled at commit so COUNT reflects count_i at acceptance
  always_comb begin
    w_status                   = '0;
    w_status[STATUS_MATCH_BIT] = w_match;
    w_status[STATUS_PEND_BIT]  = r_load_valid;
    w_rdata = '0;
    case (w_off)
      OFF_CTRL:   w_rdata = 32'(r_ctrl);
      OFF_COUNT:  w_rdata = 32'(count_i);
      OFF_CMP:    w_rdata = 32'(w_cmp);
      OFF_STATUS: w_rdata = w_status;
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl       <= '0;
      r_load_data  <= '0;
      r_load_valid <= 1'b0;
      r_ack        <= 1'b0;
      r_dat        <= '0;
    end else begin
      r_ack <= w_commit;
      r_dat <= w_commit ? w_rdata : 32'd0;
      if (w_wr_ctrl) r_ctrl <= wbs_dat_i[CTRL_W-1:0];
      if (w_wr_load) begin
        r_load_data  <= w_load_m32[BITS-1:0];
        r_load_valid <= 1'b1;
      end else if (r_load_valid && load_ready_i) begin
        r_load_valid <= 1'b0;
      end
    end
  end

`ifdef COUNTER_CMP_IRQ_EN
  logic [BITS-1:0] r_cmp;
  logic            r_match;
  logic            r_irq;
  logic [31:0]     w_cmp_m32;
  logic            w_wr_cmp;
  logic            w_w1c;
  logic            w_unused_cmp;

  assign w_cmp_m32    = (32'(r_cmp) & ~w_mask) | (wbs_dat_i & w_mask);
  assign w_wr_cmp     = w_commit & wbs_we_i & (w_off == OFF_CMP);
  assign w_w1c        = w_commit & wbs_we_i & (w_off == OFF_STATUS) & wbs_sel_i[0]
                        & wbs_dat_i[STATUS_MATCH_BIT];
  assign w_unused_cmp = ^w_cmp_m32;

  // A fresh match wins over a simultaneous write-one-to-clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmp   <= '0;
      r_match <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      if (w_wr_cmp) r_cmp <= w_cmp_m32[BITS-1:0];
      if (count_i == r_cmp) r_match <= 1'b1;
      else if (w_w1c)       r_match <= 1'b0;
      r_irq <= r_match & r_ctrl[CTRL_IRQ_EN_BIT];
    end
  end

  assign w_cmp   = r_cmp;
  assign w_match = r_match;
  assign irq_o   = r_irq;
`else
  assign w_cmp   = '0;
  assign w_match = 1'b0;
  assign irq_o   = 1'b0;
`endif

  assign wbs_ack_o    = r_ack;
  assign wbs_dat_o    = r_dat;
  assign load_valid_o = r_load_valid;
  assign load_data_o  = r_load_data;
  assign run_o        = r_ctrl[CTRL_RUN_BIT];

endmodule

// File: tb/tb_wb_counter_regs.sv
// Self-checking bench for wb_counter_regs: directed scenarios plus randomized
// register traffic checked against a behavioural register-map model.
module tb_wb_counter_regs;

  localparam int unsigned BITS = 16;
  localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef COUNTER_CMP_IRQ_EN
  localparam logic [31:0] ST_MASK = 32'hFFFF_FFFE;
`else
  localparam logic [31:0] ST_MASK = 32'hFFFF_FFFF;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]      wbs_sel_i = 4'h0;
  logic [31:0]     wbs_adr_i = 32'h0, wbs_dat_i = 32'h0;
  logic            wbs_ack_o;
  logic [31:0]     wbs_dat_o;
  logic [BITS-1:0] count_i = 16'h0042;
  logic            load_valid_o;
  logic [BITS-1:0] load_data_o;
  logic            load_ready_i = 1'b0;
  logic            run_o, irq_o;

  int checks = 0;
  int errors = 0;

  wb_counter_regs #(.BITS(BITS), .BASE_ADR(BASE)) dut (
    .clk(clk), .reset(reset),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .count_i(count_i), .load_valid_o(load_valid_o), .load_data_o(load_data_o),
    .load_ready_i(load_ready_i), .run_o(run_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  // Byte-lane write model: replace selected bytes, then keep only BITS bits.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] dat,
                                              input logic [3:0] sel);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) if (sel[b]) res[b*8 +: 8] = dat[b*8 +: 8];
    return res & ((32'd1 << BITS) - 32'd1);
  endfunction

  function automatic logic [31:0] reg_adr(input logic [2:0] off);
    return BASE + {27'd0, off, 2'b00};
  endfunction

  task automatic bus_drive(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
  endtask

  task automatic bus_idle();
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'h0;
  endtask

  task automatic wait_ack(input int max, output logic got, output logic [31:0] rd, output int lat);
    got = 1'b0; rd = 32'h0; lat = 0;
    for (int i = 1; i <= max && !got; i++) begin
      @(negedge clk);
      if (wbs_ack_o === 1'b1) begin got = 1'b1; rd = wbs_dat_o; lat = i; end
    end
  endtask

  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic got, output logic [31:0] rd,
                      output int lat);
    bus_drive(we, adr, dat, sel);
    wait_ack(8, got, rd, lat);
    bus_idle();
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] dat);
    logic g; logic [31:0] r; int l;
    xfer(1'b1, reg_adr(off), dat, 4'hF, g, r, l);
  endtask

  task automatic rd_reg(input logic [2:0] off, output logic [31:0] rd, output logic got);
    int l;
    xfer(1'b0, reg_adr(off), 32'h0, 4'hF, got, rd, l);
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic g;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks += 6;
    if (wbs_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", wbs_ack_o); end
    if (wbs_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat got %h exp 0", wbs_dat_o); end
    if (load_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", load_valid_o); end
    if (load_data_o !== 16'h0) begin errors++; $display("FAIL reset_ldata got %h exp 0", load_data_o); end
    if (run_o !== 1'b0) begin errors++; $display("FAIL reset_run got %b exp 0", run_o); end
    if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq_o); end
    reset = 1'b0;
    @(negedge clk);
    for (int o = 0; o < 5; o++) begin
      if (o == 1) continue;
      rd_reg(3'(o), rd, g);
      if (o == 2) continue;
      checks++;
      if (g !== 1'b1 || rd !== 32'h0) begin
        errors++; $display("FAIL reset_reg%0d got ack=%b %h exp ack=1 0", o, g, rd);
      end
    end
  endtask

  task automatic test_ctrl();
    logic g; logic [31:0] rd; int lat;
    @(negedge clk);
    xfer(1'b1, reg_adr(3'd0), 32'h1, 4'hF, g, rd, lat);
    checks += 2;
    if (g !== 1'b1 || lat != 1) begin errors++; $display("FAIL ctrl_ack got ack=%b lat=%0d exp ack=1 lat=1", g, lat); end
    if (run_o !== 1'b1) begin errors++; $display("FAIL ctrl_run got %b exp 1", run_o); end
    @(negedge clk);
    checks++;
    if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0) begin
      errors++; $display("FAIL ctrl_ack_len got ack=%b dat=%h exp 0 0", wbs_ack_o, wbs_dat_o);
    end
    rd_reg(3'd0, rd, g);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL ctrl_read got %h exp 1", rd); end
  endtask

  task automatic test_back_to_back();
    int acks = 0; logic prev = 1'b0; int overlaps = 0;
    @(negedge clk);
    bus_drive(1'b0, reg_adr(3'd0), 32'h0, 4'hF);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (wbs_ack_o === 1'b1) begin
        acks++;
        if (prev) overlaps++;
        checks++;
        if (wbs_dat_o !== 32'h1) begin errors++; $display("FAIL b2b_data got %h exp 1", wbs_dat_o); end
      end else begin
        checks++;
        if (wbs_dat_o !== 32'h0) begin errors++; $display("FAIL b2b_idle_data got %h exp 0", wbs_dat_o); end
      end
      prev = (wbs_ack_o === 1'b1);
    end
    bus_idle();
    checks += 2;
    if (acks != 6) begin errors++; $display("FAIL b2b_ack_count got %0d exp 6", acks); end
    if (overlaps != 0) begin errors++; $display("FAIL b2b_ack_gap got %0d exp 0", overlaps); end
    @(negedge clk);
  endtask

  task automatic test_load();
    logic g; logic [31:0] rd; int lat; int hi = 0;
    load_ready_i = 1'b0;
    xfer(1'b1, reg_adr(3'd1), 32'h0000_BEEF, 4'hF, g, rd, lat);
    checks++;
    if (g !== 1'b1) begin errors++; $display("FAIL load_ack got %b exp 1", g); end
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      if (load_valid_o !== 1'b1) break;
      hi++;
      checks++;
      if (load_data_o !== 16'hBEEF) begin errors++; $display("FAIL load_data got %h exp beef", load_data_o); end
      if (k == 4) load_ready_i = 1'b1;
    end
    load_ready_i = 1'b0;
    checks++;
    if (hi != 4) begin errors++; $display("FAIL load_valid_len got %0d exp 4", hi); end
    wr(3'd1, 32'h0000_0F0F);
    rd_reg(3'd4, rd, g);
    checks++;
    if ((rd & ST_MASK) !== 32'h2) begin errors++; $display("FAIL load_pending_status got %h exp 2", rd); end
    load_ready_i = 1'b1;
    @(negedge clk);
    load_ready_i = 1'b0;
    rd_reg(3'd4, rd, g);
    checks++;
    if ((rd & ST_MASK) !== 32'h0) begin errors++; $display("FAIL load_done_status got %h exp 0", rd); end
  endtask

  task automatic test_pending();
    logic g; logic [31:0] rd; int lat;
    load_ready_i = 1'b0;
    wr(3'd1, 32'h0000_5A5A);
    bus_drive(1'b1, reg_adr(3'd1), 32'h0000_1234, 4'hF);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (wbs_ack_o !== 1'b0 || load_data_o !== 16'h5A5A) begin
        errors++; $display("FAIL pend_hold got ack=%b data=%h exp 0 5a5a", wbs_ack_o, load_data_o);
      end
    end
    load_ready_i = 1'b1;
    @(negedge clk);
    load_ready_i = 1'b0;
    wait_ack(6, g, rd, lat);
    bus_idle();
    checks += 2;
    if (g !== 1'b1) begin errors++; $display("FAIL pend_ack got %b exp 1", g); end
    if (load_data_o !== 16'h1234 || load_valid_o !== 1'b1) begin
      errors++; $display("FAIL pend_commit got data=%h valid=%b exp 1234 1", load_data_o, load_valid_o);
    end
    load_ready_i = 1'b1;
    @(negedge clk);
    load_ready_i = 1'b0;
    @(negedge clk);
    checks++;
    if (load_valid_o !== 1'b0) begin errors++; $display("FAIL pend_drain got %b exp 0", load_valid_o); end
  endtask

  task automatic test_sel_decode();
    logic g; logic [31:0] rd, tmp, dat; logic [3:0] sel; int lat;
    logic [15:0] m_load = 16'h0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    load_ready_i = 1'b0;
    xfer(1'b1, reg_adr(3'd1), 32'h0000_FFFF, 4'h1, g, rd, lat);
    tmp = merge_bytes(32'(m_load), 32'h0000_FFFF, 4'h1);
    m_load = tmp[15:0];
    checks++;
    if (load_data_o !== m_load) begin errors++; $display("FAIL sel_lane0 got %h exp %h", load_data_o, m_load); end
    load_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dat = $urandom; sel = 4'($urandom_range(0, 15));
      tmp = merge_bytes(32'(m_load), dat, sel);
      m_load = tmp[15:0];
      xfer(1'b1, reg_adr(3'd1), dat, sel, g, rd, lat);
      checks++;
      if (load_data_o !== m_load) begin errors++; $display("FAIL sel_rand got %h exp %h", load_data_o, m_load); end
    end
    @(negedge clk);
    load_ready_i = 1'b0;
    xfer(1'b1, BASE + 32'h40, 32'hFFFF_FFFF, 4'hF, g, rd, lat);
    checks++;
    if (g !== 1'b0) begin errors++; $display("FAIL decode_wr got ack=%b exp 0", g); end
    xfer(1'b0, BASE + 32'h40, 32'h0, 4'hF, g, rd, lat);
    checks++;
    if (g !== 1'b0) begin errors++; $display("FAIL decode_rd got ack=%b exp 0", g); end
    wr(3'd6, 32'hFFFF_FFFF);
    for (int o = 5; o < 8; o++) begin
      rd_reg(3'(o), rd, g);
      checks++;
      if (g !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL hole%0d got ack=%b %h exp 1 0", o, g, rd); end
    end
  endtask

  task automatic test_irq();
    logic g; logic [31:0] rd;
    count_i = 16'h0077;
    wr(3'd3, 32'h0000_0012);
    wr(3'd4, 32'h1);
    wr(3'd0, 32'h3);
    checks++;
    if (run_o !== 1'b1) begin errors++; $display("FAIL irq_run got %b exp 1", run_o); end
    @(negedge clk);
    checks++;
    if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_idle got %b exp 0", irq_o); end
    count_i = 16'h0012;
    @(negedge clk);
    checks++;
    if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_early got %b exp 0", irq_o); end
    @(negedge clk);
    count_i = 16'h0077;
`ifdef COUNTER_CMP_IRQ_EN
    checks++;
    if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_match got %b exp 1", irq_o); end
    rd_reg(3'd4, rd, g);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL irq_status got %h exp 1", rd); end
    rd_reg(3'd3, rd, g);
    checks++;
    if (rd !== 32'h12) begin errors++; $display("FAIL irq_cmp_read got %h exp 12", rd); end
`else
    checks++;
    if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_tied got %b exp 0", irq_o); end
    rd_reg(3'd3, rd, g);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL irq_cmp_read got %h exp 0", rd); end
`endif
    wr(3'd4, 32'h1);
    repeat (2) @(negedge clk);
    checks++;
    if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_w1c got %b exp 0", irq_o); end
    rd_reg(3'd4, rd, g);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL irq_status_clr got %h exp 0", rd); end
  endtask

  task automatic test_random();
    logic g; logic [31:0] rd, dat, tmp, exp; logic [3:0] sel; logic we; int lat; int off;
    logic [1:0] m_ctrl = 2'b00;
    logic [15:0] m_cmp = 16'h0;
    wr(3'd0, 32'h0);
    wr(3'd3, 32'h0);
    for (int i = 0; i < 40; i++) begin
      off = $urandom_range(0, 7);
      if (off == 1) off = 2;
      we = 1'($urandom_range(0, 1));
      dat = $urandom;
      sel = 4'($urandom_range(0, 15));
      count_i = 16'($urandom_range(1, 65535));
      xfer(we, reg_adr(3'(off)), dat, sel, g, rd, lat);
      checks++;
      if (g !== 1'b1) begin errors++; $display("FAIL rand_ack op%0d got %b exp 1", i, g); end
      if (we) begin
        if (off == 0) begin
          tmp = merge_bytes(32'(m_ctrl), dat, sel);
          m_ctrl = tmp[1:0];
        end
`ifdef COUNTER_CMP_IRQ_EN
        if (off == 3) begin
          tmp = merge_bytes(32'(m_cmp), dat, sel);
          m_cmp = tmp[15:0];
        end
`endif
        checks++;
        if (run_o !== m_ctrl[0]) begin errors++; $display("FAIL rand_run op%0d got %b exp %b", i, run_o, m_ctrl[0]); end
      end else begin
        case (off)
          0: exp = 32'(m_ctrl);
          2: exp = 32'(count_i);
          3: exp = 32'(m_cmp);
          default: exp = 32'h0;
        endcase
        if (off == 4) rd = rd & ST_MASK;
        checks++;
        if (rd !== exp) begin errors++; $display("FAIL rand_read op%0d off%0d got %h exp %h", i, off, rd, exp); end
      end
    end
  endtask

  task automatic test_reset_wait();
    logic g; logic [31:0] rd;
    count_i = 16'h0042;
    wr(3'd0, 32'h1);
    load_ready_i = 1'b0;
    wr(3'd1, 32'h0000_AAAA);
    bus_drive(1'b1, reg_adr(3'd1), 32'h0000_BBBB, 4'hF);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks += 2;
    if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0 || load_valid_o !== 1'b0) begin
      errors++; $display("FAIL rstw_bus got ack=%b dat=%h valid=%b exp 0 0 0", wbs_ack_o, wbs_dat_o, load_valid_o);
    end
    if (load_data_o !== 16'h0 || run_o !== 1'b0 || irq_o !== 1'b0) begin
      errors++; $display("FAIL rstw_regs got data=%h run=%b irq=%b exp 0 0 0", load_data_o, run_o, irq_o);
    end
    reset = 1'b0;
    bus_idle();
    @(negedge clk);
    for (int o = 0; o < 5; o++) begin
      if (o == 1 || o == 2) continue;
      rd_reg(3'(o), rd, g);
      checks++;
      if (g !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL rstw_reg%0d got ack=%b %h exp 1 0", o, g, rd); end
    end
  endtask

  initial begin
    test_reset();
    test_ctrl();
    test_back_to_back();
    test_load();
    test_pending();
    test_sel_decode();
    test_irq();
    test_random();
    test_reset_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_counter_regs.md
WB_COUNTER_REGS -- requirements
Module: wb_counter_regs

Interface
REQ-001 SHALL have parameter BITS, default 16, width of the counter value, load and compare registers (1..32).
REQ-002 SHALL have parameter BASE_ADR, default 32'h3000_0000, byte address of register 0; decode uses wbs_adr_i[31:5] against BASE_ADR[31:5].
REQ-003 SHALL have port clk  input  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 SHALL have ports wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone classic cycle, strobe and write-enable.
REQ-006 SHALL have port wbs_sel_i  input  4  byte lane enables.
REQ-007 SHALL have ports wbs_adr_i, wbs_dat_i  input  32 each  address and write data.
REQ-008 SHALL have ports wbs_ack_o  output  1 and wbs_dat_o  output  32  acknowledge and read data.
REQ-009 SHALL have port count_i  input  BITS  live value from the downstream counter.
REQ-010 SHALL have ports load_valid_o  output  1, load_data_o  output  BITS, load_ready_i  input  1  load handshake to the counter.
REQ-011 SHALL have ports run_o  output  1 (counter enable) and irq_o  output  1 (compare interrupt).

Function
REQ-012 SHALL map word offsets wbs_adr_i[4:2]: 0 CTRL (bit0 run, bit1 irq_en), 1 LOAD (WO), 2 COUNT (RO), 3 CMP, 4 STATUS (bit0 match W1C, bit1 load_pending RO); offsets 5-7 read 0, writes ignored.
REQ-013 SHALL run FSM IDLE -> ACK -> IDLE; IDLE -> WAIT_LOAD -> ACK for a LOAD write while load_pending is set.
REQ-014 SHALL accept a request in IDLE when cyc&stb are high and the address decodes; non-decoding requests SHALL never be acked.
REQ-015 SHALL assert wbs_ack_o for exactly one cycle, one cycle after acceptance; ack SHALL be low for at least one cycle between transfers.
REQ-016 SHALL drive wbs_dat_o with zero-extended register data only while wbs_ack_o is high, otherwise 0; COUNT reads return count_i sampled at acceptance.
REQ-017 SHALL apply writes per byte lane where wbs_sel_i[n] is set; bits at or above BITS are discarded.
REQ-018 SHALL, on a LOAD write, set load_data_o to the merged value and raise load_valid_o (load_pending) in the ack cycle; hold both stable until load_ready_i is sampled high, then clear load_valid_o next cycle.
REQ-019 SHALL, for a LOAD write arriving while load_pending, stay in WAIT_LOAD (no ack) until the pending transfer completes, then commit and ack.
REQ-020 SHALL drop an in-flight transfer without ack if cyc or stb falls before acceptance; once accepted, the ack SHALL still issue.
REQ-021 SHALL drive run_o directly from CTRL.run.

Reset
REQ-022 SHALL, on reset, clear FSM to IDLE, wbs_ack_o, wbs_dat_o, load_valid_o, load_data_o, run_o, irq_o, CTRL, CMP and STATUS to 0, abandoning any pending load or access mid-operation.

Configuration
REQ-023 SHALL, with COUNTER_CMP_IRQ_EN defined, set STATUS.match when count_i == CMP (registered, one cycle later), assert irq_o = STATUS.match & CTRL.irq_en, and let a simultaneous W1C clear lose to a new match.
REQ-024 SHALL, without COUNTER_CMP_IRQ_EN, read CMP and STATUS.match as 0, ignore their writes, tie irq_o to 0 and omit compare logic.

Structure
REQ-025 SHALL place register offsets, CTRL/STATUS bit positions and the FSM state enum in shared package counter_regs_pkg.
REQ-026 SHALL be a single module; no sub-module is required.

Verification
REQ-027 SHALL cover: write CTRL=0x1, sel=0xF -> ack 1 cycle later for 1 cycle, run_o=1.
REQ-028 SHALL cover: write LOAD=0xBEEF with load_ready_i low 3 cycles -> load_valid_o high 4 cycles, load_data_o=0xBEEF stable, STATUS.bit1=1 meanwhile.
REQ-029 SHALL cover: second LOAD=0x1234 during pending load -> no ack until first completes, then ack, load_data_o=0x1234.
REQ-030 SHALL cover: write LOAD=0xFFFF with sel=0x1 over LOAD reset value 0 -> load_data_o=0x00FF; adr=BASE+0x40 -> no ack ever.
REQ-031 SHALL cover: CMP=0x0012, irq_en=1, count_i=0x0012 -> irq_o high 2 cycles after the match; W1C STATUS=0x1 with count_i!=CMP -> irq_o low (macro defined); irq_o constant 0 (macro undefined).
REQ-032 SHALL cover: reset asserted during WAIT_LOAD -> next cycle ack=0, load_valid_o=0, all registers 0.
